// File: rtl/serial_add_bcd_ctrl_if.sv
// Bundle between the add/BCD sequencer, the switch/key side and the shared
// 1-bit full-adder slice.
interface serial_add_bcd_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;
  logic             op_err;

  modport master (
    output start, a, b, cin, fa_sum, fa_cout,
    input  fa_a, fa_b, fa_cin, busy, done, sum, bcd_tens, bcd_ones, op_err
  );

  modport slave (
    input  start, a, b, cin, fa_sum, fa_cout,
    output fa_a, fa_b, fa_cin, busy, done, sum, bcd_tens, bcd_ones, op_err
  );
endinterface

// File: rtl/serial_add_bcd_ctrl.sv
// Bit-serial adder sequencer around one shared full-adder slice, followed by a
// sequential double-dabble conversion of the sum into two BCD digits.
module serial_add_bcd_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  serial_add_bcd_ctrl_if.slave bus
);

  localparam int DDW = WIDTH + 9;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ADD_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, CONV, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   sum_reg;
  logic [DDW-1:0]   dd_reg;
  logic [3:0]       tens_reg;
  logic [3:0]       ones_reg;
  logic             err_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [DDW-1:0]   dd_adj;
  logic [DDW-1:0]   dd_next;
  logic [WIDTH:0]   sum_next;

  // Double-dabble correction on the tens and ones nibbles of {tens, ones, bin}.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dabble
      assign dd_adj[WIDTH+1+4*gi +: 4] = (dd_reg[WIDTH+1+4*gi +: 4] >= 4'd5)
                                       ? dd_reg[WIDTH+1+4*gi +: 4] + 4'd3
                                       : dd_reg[WIDTH+1+4*gi +: 4];
    end
  endgenerate
  assign dd_adj[WIDTH:0] = dd_reg[WIDTH:0];
  assign dd_next         = dd_adj << 1;

  // The final carry lands in the top bit only on the last ADD edge.
  assign sum_next = {(cnt_reg == ADD_LAST) ? bus.fa_cout : 1'b0,
                     bus.fa_sum, sum_reg[WIDTH-1:1]};

  // Operand and carry registers drain to zero by the end of ADD, so the slice
  // inputs are naturally 0 in IDLE, CONV and DONE.
  assign bus.fa_a     = a_reg[0];
  assign bus.fa_b     = b_reg[0];
  assign bus.fa_cin   = carry_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.sum      = sum_reg;
  assign bus.bcd_tens = tens_reg;
  assign bus.bcd_ones = ones_reg;
  assign bus.op_err   = err_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      dd_reg    <= '0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= (32'(bus.a) > 32'd9) || (32'(bus.b) > 32'd9);
            busy_reg  <= 1'b1;
            state_reg <= ADD;
          end
        end
        ADD: begin
          sum_reg <= sum_next;
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          if (cnt_reg == ADD_LAST) begin
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            dd_reg    <= {8'd0, sum_next};
            state_reg <= CONV;
          end else begin
            carry_reg <= bus.fa_cout;
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        CONV: begin
          dd_reg <= dd_next;
          if (cnt_reg == CONV_LAST) begin
            tens_reg  <= dd_next[DDW-1 -: 4];
            ones_reg  <= dd_next[DDW-5 -: 4];
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_bcd_ctrl.sv
// Bench for serial_add_bcd_ctrl: table vectors, corner sequences and random
// operands checked against an arithmetic reference model.
module tb_serial_add_bcd_ctrl;

  localparam int W      = 4;
  localparam int LAT    = 2 * W + 1;
  localparam int PERIOD = 2 * W + 3;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  serial_add_bcd_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_bcd_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  // Shared full-adder slice
  assign {bus.fa_cout, bus.fa_sum} = 2'(bus.fa_a) + 2'(bus.fa_b) + 2'(bus.fa_cin);

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           sum;
    int           tens;
    int           ones;
    int           err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int a, input int b, input int cin,
                                output int s, output int t, output int o, output int e);
    s = a + b + cin;
    t = s / 10;
    o = s % 10;
    e = (a > 9 || b > 9) ? 1 : 0;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int es, input int et, input int eo, input int ee,
                       input string tag);
    int lat;
    logic [W-1:0] fa_a_seen;
    logic [W-1:0] fa_b_seen;
    fa_a_seen = '0;
    fa_b_seen = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    check({tag, ".busy_add"}, int'(bus.busy), 1);
    check({tag, ".fa_cin0"}, int'(bus.fa_cin), int'(cin));
    while (!bus.done && lat < 40) begin
      if (lat < W) begin
        fa_a_seen[lat] = bus.fa_a;
        fa_b_seen[lat] = bus.fa_b;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".fa_a_seq"}, int'(fa_a_seen), int'(a));
    check({tag, ".fa_b_seq"}, int'(fa_b_seen), int'(b));
    check({tag, ".sum"}, int'(bus.sum), es);
    check({tag, ".tens"}, int'(bus.bcd_tens), et);
    check({tag, ".ones"}, int'(bus.bcd_ones), eo);
    check({tag, ".op_err"}, int'(bus.op_err), ee);
    check({tag, ".busy_done"}, int'(bus.busy), 0);
    $display("op %s: a=%0d b=%0d cin=%0d -> sum=%0d bcd=%0d%0d err=%0d lat=%0d",
             tag, a, b, cin, bus.sum, bus.bcd_tens, bus.bcd_ones, bus.op_err, lat);
    @(negedge clk);
    check({tag, ".done_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    int s, t, o, e, lat, ndone, cyc, extra;
    int tdone[3];
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{4'd3,  4'd4,  1'b0, 7,  0, 7, 0};
    vecs[1] = '{4'd9,  4'd9,  1'b1, 19, 1, 9, 0};
    vecs[2] = '{4'd15, 4'd15, 1'b1, 31, 3, 1, 1};
    vecs[3] = '{4'd2,  4'd2,  1'b0, 4,  0, 4, 0};
    vecs[4] = '{4'd0,  4'd0,  1'b0, 0,  0, 0, 0};
    vecs[5] = '{4'd15, 4'd0,  1'b0, 15, 1, 5, 1};
    vecs[6] = '{4'd9,  4'd0,  1'b0, 9,  0, 9, 0};
    vecs[7] = '{4'd10, 4'd9,  1'b1, 20, 2, 0, 1};
    vecs[8] = '{4'd15, 4'd15, 1'b0, 30, 3, 0, 1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    check("rst.sum", int'(bus.sum), 0);
    check("rst.bcd", int'({bus.bcd_tens, bus.bcd_ones}), 0);
    check("rst.op_err", int'(bus.op_err), 0);
    check("rst.fa", int'({bus.fa_a, bus.fa_b, bus.fa_cin}), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].tens,
            vecs[i].ones, vecs[i].err, $sformatf("vec%0d", i));

    // start re-pulsed during ADD and during DONE must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd7; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (lat == 2) begin
        bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
      end else begin
        bus.start = 1'b0; bus.a = 4'd5; bus.b = 4'd7;
      end
      @(negedge clk);
      lat++;
    end
    check("repulse.latency", lat, LAT);
    check("repulse.sum", int'(bus.sum), 12);
    check("repulse.bcd", int'({bus.bcd_tens, bus.bcd_ones}), 8'h12);
    $display("op repulse: a=5 b=7 cin=0 -> sum=%0d lat=%0d", bus.sum, lat);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.busy || bus.done) extra++;
      @(negedge clk);
    end
    check("repulse.no_restart", extra, 0);

    // reset on the third ADD cycle discards the partial result
    bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd8; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.busy", int'(bus.busy), 0);
    check("midrst.done", int'(bus.done), 0);
    check("midrst.sum", int'(bus.sum), 0);
    check("midrst.bcd", int'({bus.bcd_tens, bus.bcd_ones}), 0);
    check("midrst.op_err", int'(bus.op_err), 0);
    check("midrst.fa", int'({bus.fa_a, bus.fa_b, bus.fa_cin}), 0);
    $display("op midrst: reset during ADD, busy=%0d sum=%0d", bus.busy, bus.sum);
    do_op(4'd5, 4'd6, 1'b0, 11, 1, 1, 0, "after_rst");

    // start held high: back-to-back operations
    bus.start = 1'b1; bus.a = 4'd0; bus.b = 4'd0; bus.cin = 1'b1;
    ndone = 0;
    cyc = 0;
    while (ndone < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        tdone[ndone] = cyc;
        check($sformatf("held%0d.sum", ndone), int'(bus.sum), 1);
        check($sformatf("held%0d.bcd", ndone), int'({bus.bcd_tens, bus.bcd_ones}), 8'h01);
        $display("op held%0d: a=0 b=0 cin=1 -> sum=%0d at cycle %0d", ndone, bus.sum, cyc);
        ndone++;
      end
    end
    bus.start = 1'b0;
    check("held.count", ndone, 3);
    if (ndone == 3) begin
      check("held.gap1", tdone[1] - tdone[0], PERIOD);
      check("held.gap2", tdone[2] - tdone[1], PERIOD);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("held.no_extra", extra, 0);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      model(int'(ra), int'(rb), int'(rc), s, t, o, e);
      do_op(ra, rb, rc, s, t, o, e, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
